regfile_wb_arbiter: RTL
=======================

Name: regfile_wb_arbiter

Overview:
- Owns the single write port (we3/ra3/wd3/selec_v_s_w/cmd) of the scalar/vector register file.
- Round-robin arbitrates between two writeback requesters: ALU and memory load unit.
- Tracks a busy-bit scoreboard per destination register, set at issue and cleared at writeback grant.
- Drives the decode-stage stall for RAW and WAW hazards.

Parameters:
DW, 32, lane data width
LANES, 16, lanes per vector register (lane 15 doubles as the scalar value)
AW, 4, register index width

Ports:
clk  in  1  clock, posedge
rst  in  1  asynchronous reset, active-high
alu_valid  in  1  ALU writeback request
alu_ready  out  1  ALU request granted this cycle
alu_rd  in  AW  ALU destination index
alu_vec  in  1  ALU destination is vector class
alu_cmd  in  3  ALU command forwarded to RF cmd
alu_data  in  LANES*DW  ALU result, lane 15 = scalar
mem_valid  in  1  memory writeback request
mem_ready  out  1  memory request granted this cycle
mem_rd  in  AW  memory destination index
mem_vec  in  1  memory destination is vector class
mem_cmd  in  3  memory command forwarded to RF cmd
mem_data  in  LANES*DW  load result
issue_en  in  1  decode issues an instruction with a destination
issue_rd  in  AW  issued destination index
issue_vec  in  1  issued destination class flag
issue_cmd  in  3  issued command
ra1  in  AW  decode source 1 index
ra2  in  AW  decode source 2 index
src1_vec  in  1  source 1 class
src2_vec  in  1  source 2 class
stall  out  1  decode must hold
we3  out  1  RF write enable
ra3  out  AW  RF write index
wd3  out  LANES*DW  RF write data
selec_v_s_w  out  1  RF write class
cmd  out  3  RF command
conflict_cnt  out  32  cycles in which both requesters were valid

Behaviour:
- Effective class rule:
  - A destination is scalar if vec=0, or if vec=1 and cmd=3'b101.
  - It is vector otherwise.
  - Applies identically at issue and at grant.
- Scoreboard: two 16-bit vectors, sb_s and sb_v, both 0 at reset.
  - Scalar index 15 (PC) is never set; an issue targeting it is ignored by the scoreboard.
- Arbitration is combinational within the cycle:
  - Only one valid requester: that requester is granted.
  - Both valid: grant the requester not granted last. A last_grant flop resets to MEM, so the first contention goes to ALU.
  - last_grant updates only on a grant.
  - alu_ready/mem_ready equal the grant. A transfer completes when valid&ready at posedge.
  - Requesters hold valid and payload stable until ready.
- Write port outputs are registered with 1-cycle latency:
  - At the posedge of a grant: we3<=1; ra3, wd3, selec_v_s_w, cmd<=winner's rd, data, vec, cmd.
  - No grant: we3<=0; the other outputs hold.
  - The RF samples on the following negedge.
  - Reset values: we3=0, ra3=0, wd3=0, selec_v_s_w=0, cmd=0.
- Scoreboard update at posedge:
  - Clear the granted destination's bit in its effective class.
  - Set sb[class][issue_rd] when issue_en=1 and stall=0.
  - Same register and class set and cleared in one cycle: set wins.
- stall is combinational and equals the OR of:
  - sb[src1 class][ra1]
  - sb[src2 class][ra2]
  - issue_en & sb[dst class][issue_rd] (WAW)
  - Scalar index 15 sources never stall.
- conflict_cnt:
  - Increments when alu_valid&mem_valid.
  - Wraps at 2^32.
  - Resets to 0.
- Reset mid-operation:
  - All state clears immediately and asynchronously: scoreboard, we3, last_grant, counter.
  - Requests pending at reset are dropped. Requesters must re-present them after reset.

Test Plan:
- Reset then idle -> we3=0, stall=0, conflict_cnt=0, all ready=0.
- ALU alone writes vector v3 (alu_vec=1, cmd=000, data lanes=i) -> alu_ready=1 same cycle; next cycle we3=1, ra3=3, selec_v_s_w=1, wd3 lane i=i.
- Both valid for 4 consecutive cycles, each holding valid after grant -> grants alternate ALU, MEM, ALU, MEM; conflict_cnt=4.
- Issue scalar r5 → subsequent decode with ra1=5, src1_vec=0 stalls → ALU grant for r5 clears sb_s[5] → stall=0 on the following cycle.
- Issue vec=1, cmd=101, rd=2 → sb_s[2] is set (sb_v[2] unchanged) → a vector source v2 does not stall.
- Assert rst while sb_v[7]=1 and we3=1 -> sb_v=0, we3=0 immediately; ALU grant the cycle after reset release is honoured normally.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request channels (ALU, memory) and the register-file write port
// seen by the regfile_wb_arbiter.
interface regfile_wb_arbiter_if #(
    parameter int DW    = 32,
    parameter int LANES = 16,
    parameter int AW    = 4
);
    logic                  alu_valid;
    logic                  alu_ready;
    logic [AW-1:0]         alu_rd;
    logic                  alu_vec;
    logic [2:0]            alu_cmd;
    logic [LANES*DW-1:0]   alu_data;

    logic                  mem_valid;
    logic                  mem_ready;
    logic [AW-1:0]         mem_rd;
    logic                  mem_vec;
    logic [2:0]            mem_cmd;
    logic [LANES*DW-1:0]   mem_data;

    logic                  we3;
    logic [AW-1:0]         ra3;
    logic [LANES*DW-1:0]   wd3;
    logic                  selec_v_s_w;
    logic [2:0]            cmd;

    // valid/ready: a transfer completes at a posedge where valid & ready are both 1;
    // requesters keep valid and payload stable until ready, ready is a same-cycle grant.
    modport master (
        output alu_valid, alu_rd, alu_vec, alu_cmd, alu_data,
        output mem_valid, mem_rd, mem_vec, mem_cmd, mem_data,
        input  alu_ready, mem_ready,
        input  we3, ra3, wd3, selec_v_s_w, cmd
    );

    modport slave (
        input  alu_valid, alu_rd, alu_vec, alu_cmd, alu_data,
        input  mem_valid, mem_rd, mem_vec, mem_cmd, mem_data,
        output alu_ready, mem_ready,
        output we3, ra3, wd3, selec_v_s_w, cmd
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter owning the register-file write port, with a
// per-register busy scoreboard that drives the decode RAW/WAW stall.
module regfile_wb_arbiter #(
    parameter int DW    = 32,
    parameter int LANES = 16,
    parameter int AW    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_wb_arbiter_if.slave  wb,
    input  logic                 issue_en,
    input  logic [AW-1:0]        issue_rd,
    input  logic                 issue_vec,
    input  logic [2:0]           issue_cmd,
    input  logic [AW-1:0]        ra1,
    input  logic [AW-1:0]        ra2,
    input  logic                 src1_vec,
    input  logic                 src2_vec,
    output logic                 stall,
    output logic [31:0]          conflict_cnt
);
    localparam int             NREG       = 1 << AW;
    localparam logic [AW-1:0]  PC_IDX     = '1;
    localparam logic [2:0]     CMD_SCALAR = 3'b101;

    logic                 last_mem_q, last_mem_d;
    logic [NREG-1:0]      sb_s_q, sb_s_d;
    logic [NREG-1:0]      sb_v_q, sb_v_d;
    logic                 we3_q, we3_d;
    logic [AW-1:0]        ra3_q, ra3_d;
    logic [LANES*DW-1:0]  wd3_q, wd3_d;
    logic                 sel_q, sel_d;
    logic [2:0]           cmd_q, cmd_d;
    logic [31:0]          conflict_q, conflict_d;

    logic                 grant_alu, grant_mem;
    logic [AW-1:0]        win_rd;
    logic                 win_vec;
    logic [2:0]           win_cmd;
    logic [LANES*DW-1:0]  win_data;
    logic                 win_isv, iss_isv;
    logic                 src1_hit, src2_hit, waw_hit;

    always_comb begin
        // last_mem_q=1 means MEM won last time, so ALU takes the next contention
        grant_alu = wb.alu_valid & (~wb.mem_valid | last_mem_q);
        grant_mem = wb.mem_valid & ~grant_alu;

        win_rd   = grant_alu ? wb.alu_rd   : wb.mem_rd;
        win_vec  = grant_alu ? wb.alu_vec  : wb.mem_vec;
        win_cmd  = grant_alu ? wb.alu_cmd  : wb.mem_cmd;
        win_data = grant_alu ? wb.alu_data : wb.mem_data;

        // vec=1 with the scalar-extract command lands in the scalar class
        win_isv = win_vec & (win_cmd != CMD_SCALAR);
        iss_isv = issue_vec & (issue_cmd != CMD_SCALAR);

        src1_hit = src1_vec ? sb_v_q[ra1] : ((ra1 != PC_IDX) & sb_s_q[ra1]);
        src2_hit = src2_vec ? sb_v_q[ra2] : ((ra2 != PC_IDX) & sb_s_q[ra2]);
        waw_hit  = issue_en & (iss_isv ? sb_v_q[issue_rd] : sb_s_q[issue_rd]);
        stall    = src1_hit | src2_hit | waw_hit;

        last_mem_d = last_mem_q;
        sb_s_d     = sb_s_q;
        sb_v_d     = sb_v_q;
        we3_d      = 1'b0;
        ra3_d      = ra3_q;
        wd3_d      = wd3_q;
        sel_d      = sel_q;
        cmd_d      = cmd_q;
        conflict_d = conflict_q + {31'd0, wb.alu_valid & wb.mem_valid};

        if (grant_alu | grant_mem) begin
            we3_d      = 1'b1;
            ra3_d      = win_rd;
            wd3_d      = win_data;
            sel_d      = win_vec;
            cmd_d      = win_cmd;
            last_mem_d = grant_mem;
            if (win_isv) sb_v_d[win_rd] = 1'b0;
            else         sb_s_d[win_rd] = 1'b0;
        end

        // Applied after the clear so a same-cycle set wins
        if (issue_en & ~stall) begin
            if (iss_isv)                   sb_v_d[issue_rd] = 1'b1;
            else if (issue_rd != PC_IDX)   sb_s_d[issue_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_mem_q <= 1'b1;
            sb_s_q     <= '0;
            sb_v_q     <= '0;
            we3_q      <= 1'b0;
            ra3_q      <= '0;
            wd3_q      <= '0;
            sel_q      <= 1'b0;
            cmd_q      <= 3'b000;
            conflict_q <= 32'd0;
        end else begin
            last_mem_q <= last_mem_d;
            sb_s_q     <= sb_s_d;
            sb_v_q     <= sb_v_d;
            we3_q      <= we3_d;
            ra3_q      <= ra3_d;
            wd3_q      <= wd3_d;
            sel_q      <= sel_d;
            cmd_q      <= cmd_d;
            conflict_q <= conflict_d;
        end
    end

    assign wb.alu_ready      = grant_alu;
    assign wb.mem_ready      = grant_mem;
    assign wb.we3            = we3_q;
    assign wb.ra3            = ra3_q;
    assign wb.wd3            = wd3_q;
    assign wb.selec_v_s_w    = sel_q;
    assign wb.cmd            = cmd_q;
    assign conflict_cnt      = conflict_q;
endmodule
